// File: rtl/avalon_slave_pkg.sv
// Shared constants and types for the Avalon-MM pipelined slave.
package avalon_slave_pkg;

    // Feedback mask for x^8 + x^6 + x^5 + x^4 + 1 (bits 7, 5, 4, 3)
    localparam logic [7:0] LFSR_TAPS         = 8'hB8;
    localparam logic [7:0] LFSR_SEED_DEFAULT = 8'hA5;

    typedef enum logic {
        MODE_FIXED,
        MODE_VARIABLE
    } slave_mode_e;

    function automatic int calc_dw(input int nbytes);
        return 8 * nbytes;
    endfunction

endpackage

// File: rtl/avalon_rdata_fifo.sv
// Synchronous read-return FIFO with show-ahead head word; DEPTH must be a power of two.
module avalon_rdata_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 16,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; only pointers and count define validity
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/avalon_pipeline_slave.sv
// Avalon-MM pipelined slave: byte-enabled register memory with fixed- or
// variable-latency (LFSR-stalled) in-order read return.
module avalon_pipeline_slave
    import avalon_slave_pkg::*;
#(
    parameter  int         NBDATABYTES = 2,
    parameter  int         NBADDRBITS  = 8,
    parameter  int         VARIABLE    = 0,
    parameter  int         FIXEDDELAY  = 2,
    parameter  int         MAXPENDING  = 4,
    parameter  logic [7:0] LFSRSEED    = LFSR_SEED_DEFAULT,
    localparam int         DW          = calc_dw(NBDATABYTES)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NBADDRBITS-1:0]  address,
    input  logic [NBDATABYTES-1:0] byteenable,
    input  logic                   read,
    input  logic                   write,
    input  logic [DW-1:0]          writedata,
    output logic                   waitrequest,
    output logic [DW-1:0]          readdata,
    output logic                   readdatavalid
);

    localparam slave_mode_e MODE = (VARIABLE != 0) ? MODE_VARIABLE : MODE_FIXED;

    if (FIXEDDELAY < 1 || FIXEDDELAY > 8 || MAXPENDING < 2 ||
        (MAXPENDING & (MAXPENDING - 1)) != 0 || LFSRSEED == 8'h00) begin : g_bad_params
        $error("avalon_pipeline_slave: illegal parameter combination");
    end

    logic [DW-1:0] mem [2**NBADDRBITS];
    logic [DW-1:0] mem_word;
    logic          wr_acc;
    logic          rd_acc;
    logic [DW-1:0] rdata_q;
    logic          rvalid_q;

    // The read samples the pre-write word, so a same-edge write stays invisible
    assign mem_word = mem[address];
    assign wr_acc   = write && !waitrequest;
    assign rd_acc   = read && !write && !waitrequest;

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            for (int i = 0; i < NBDATABYTES; i++) begin
                if (byteenable[i]) mem[address][8*i +: 8] <= writedata[8*i +: 8];
            end
        end
    end

    if (MODE == MODE_FIXED) begin : g_fixed
        logic [FIXEDDELAY-1:0] pipe_v;
        logic [DW-1:0]         pipe_d [FIXEDDELAY];

        assign waitrequest = rst;

        always_ff @(posedge clk) begin
            if (rst) begin
                pipe_v <= '0;
                for (int i = 0; i < FIXEDDELAY; i++) pipe_d[i] <= '0;
            end else begin
                pipe_v[0] <= rd_acc;
                pipe_d[0] <= mem_word;
                for (int i = 1; i < FIXEDDELAY; i++) begin
                    pipe_v[i] <= pipe_v[i-1];
                    pipe_d[i] <= pipe_d[i-1];
                end
            end
        end

        assign rvalid_q = pipe_v[FIXEDDELAY-1];
        assign rdata_q  = pipe_d[FIXEDDELAY-1];
    end else begin : g_variable
        localparam int CW = $clog2(MAXPENDING) + 1;

        logic [7:0]    lfsr;
        logic [CW-1:0] count;
        logic [DW-1:0] head;
        logic          full;
        logic          empty;
        logic          pop;

        always_ff @(posedge clk) begin
            if (rst) lfsr <= LFSRSEED;
            else     lfsr <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
        end

        // Uses the pre-pop count: a read is never accepted at full
        assign waitrequest = rst || (count == CW'(MAXPENDING)) || lfsr[0];
        assign pop         = !empty && lfsr[1];

        avalon_rdata_fifo #(
            .DEPTH (MAXPENDING),
            .WIDTH (DW)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (rd_acc && !full),
            .pop   (pop),
            .wdata (mem_word),
            .rdata (head),
            .full  (full),
            .empty (empty),
            .count (count)
        );

        always_ff @(posedge clk) begin
            if (rst) begin
                rdata_q  <= '0;
                rvalid_q <= 1'b0;
            end else begin
                rvalid_q <= pop;
                if (pop) rdata_q <= head;
            end
        end
    end

    assign readdata      = rdata_q;
    assign readdatavalid = rvalid_q;

endmodule

// File: tb/tb_avalon_pipeline_slave.sv
// Scoreboard bench: one fixed-latency and one variable-latency slave instance.
module tb_avalon_pipeline_slave;

    localparam int FD   = 2;
    localparam int MAXP = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        f_rst, f_read, f_write, f_waitrequest, f_readdatavalid;
    logic [7:0]  f_address;
    logic [1:0]  f_byteenable;
    logic [15:0] f_writedata, f_readdata;
    logic        v_rst, v_read, v_write, v_waitrequest, v_readdatavalid;
    logic [7:0]  v_address;
    logic [1:0]  v_byteenable;
    logic [15:0] v_writedata, v_readdata;

    avalon_pipeline_slave #(
        .NBDATABYTES(2), .NBADDRBITS(8), .VARIABLE(0), .FIXEDDELAY(FD), .MAXPENDING(MAXP), .LFSRSEED(8'hA5)
    ) u_fix (
        .clk(clk), .rst(f_rst), .address(f_address), .byteenable(f_byteenable),
        .read(f_read), .write(f_write), .writedata(f_writedata),
        .waitrequest(f_waitrequest), .readdata(f_readdata), .readdatavalid(f_readdatavalid)
    );

    avalon_pipeline_slave #(
        .NBDATABYTES(2), .NBADDRBITS(8), .VARIABLE(1), .FIXEDDELAY(FD), .MAXPENDING(MAXP), .LFSRSEED(8'hA5)
    ) u_var (
        .clk(clk), .rst(v_rst), .address(v_address), .byteenable(v_byteenable),
        .read(v_read), .write(v_write), .writedata(v_writedata),
        .waitrequest(v_waitrequest), .readdata(v_readdata), .readdatavalid(v_readdatavalid)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] fmem [256];
    logic [15:0] vmem [256];
    logic [15:0] qd_f[$], qd_v[$];
    int          qc_f[$], qc_v[$];
    int          pend_v = 0;
    int          v_rets = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_msg(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
    endtask

    always @(negedge clk) begin
        if (f_readdatavalid) begin
            if (qd_f.size() == 0) begin
                fail_msg("fix_unexpected_rdv");
            end else begin
                check("fix_rdata", f_readdata, qd_f.pop_front());
                check("fix_latency", cyc, qc_f.pop_front());
            end
        end
        if (v_readdatavalid) begin
            v_rets++;
            if (qd_v.size() == 0) begin
                fail_msg("var_unexpected_rdv");
            end else begin
                check("var_rdata", v_readdata, qd_v.pop_front());
                check("var_latency_min", (cyc >= qc_v.pop_front()) ? 1 : 0, 1);
                pend_v--;
            end
        end
    end

    // One request on instance v (1) or f (0); returns at the drive point where it is accepted.
    task automatic req(input bit v, input bit rd, input bit wr, input logic [7:0] a,
                       input logic [15:0] d, input logic [1:0] be);
        int   waits = 0;
        logic wq;
        @(negedge clk); #1;
        if (v) begin
            v_read = rd; v_write = wr; v_address = a; v_writedata = d; v_byteenable = be;
        end else begin
            f_read = rd; f_write = wr; f_address = a; f_writedata = d; f_byteenable = be;
        end
        forever begin
            wq = v ? v_waitrequest : f_waitrequest;
            if (v && pend_v == MAXP) check("var_waitreq_at_full", wq, 1);
            if (!v) check("fix_waitreq_low", wq, 0);
            if (!wq) break;
            waits++;
            if (waits > 200) begin
                fail_msg("req_accept");
                return;
            end
            @(negedge clk); #1;
        end
        if (wr) begin
            for (int i = 0; i < 2; i++) begin
                if (be[i]) begin
                    if (v) vmem[a][8*i +: 8] = d[8*i +: 8];
                    else   fmem[a][8*i +: 8] = d[8*i +: 8];
                end
            end
        end else if (rd) begin
            if (v) begin
                qd_v.push_back(vmem[a]); qc_v.push_back(cyc + 2); pend_v++;
            end else begin
                qd_f.push_back(fmem[a]); qc_f.push_back(cyc + FD);
            end
        end
    endtask

    task automatic idle(input bit v);
        @(negedge clk); #1;
        if (v) begin v_read = 1'b0; v_write = 1'b0; end
        else   begin f_read = 1'b0; f_write = 1'b0; end
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while ((qd_f.size() != 0 || qd_v.size() != 0) && n < bound) begin
            @(negedge clk); #1;
            n++;
        end
        check("drain_empty", qd_f.size() + qd_v.size(), 0);
    endtask

    task automatic reset_mid();
        int k = 0;
        int base;
        logic [7:0] a;
        @(negedge clk); #1;
        while (pend_v != 3 && k < 300) begin
            a = 8'(k % 20);
            v_read = 1'b1; v_write = 1'b0; v_address = a;
            if (!v_waitrequest) begin
                qd_v.push_back(vmem[a]); qc_v.push_back(cyc + 2); pend_v++;
            end
            k++;
            @(negedge clk); #1;
        end
        check("rst_mid_pending3", pend_v, 3);
        v_read = 1'b0;
        v_rst  = 1'b1;
        qd_v.delete(); qc_v.delete(); pend_v = 0;
        base = v_rets;
        @(negedge clk); #1;
        check("rst_mid_waitreq", v_waitrequest, 1);
        check("rst_mid_rdv_low", v_readdatavalid, 0);
        v_rst = 1'b0;
        repeat (30) @(negedge clk);
        #1;
        check("rst_mid_no_returns", v_rets - base, 0);
    endtask

    initial begin
        int base;
        f_rst = 1'b1; f_read = 1'b0; f_write = 1'b0; f_address = '0; f_byteenable = '0; f_writedata = '0;
        v_rst = 1'b1; v_read = 1'b0; v_write = 1'b0; v_address = '0; v_byteenable = '0; v_writedata = '0;
        repeat (3) @(negedge clk);
        #1;
        check("fix_rst_waitreq", f_waitrequest, 1);
        check("fix_rst_rdv", f_readdatavalid, 0);
        check("fix_rst_rdata", f_readdata, 0);
        check("var_rst_waitreq", v_waitrequest, 1);
        check("var_rst_rdv", v_readdatavalid, 0);
        check("var_rst_rdata", v_readdata, 0);
        f_rst = 1'b0; v_rst = 1'b0;

        // Fixed: single read, byte merge, read+write, read-around-write, back-to-back
        req(0, 0, 1, 8'h10, 16'hBEEF, 2'b11);
        req(0, 1, 0, 8'h10, 16'h0, 2'b00);
        idle(0);
        repeat (4) @(negedge clk);
        req(0, 0, 1, 8'h03, 16'h1234, 2'b11);
        req(0, 0, 1, 8'h03, 16'hABCD, 2'b01);
        req(0, 1, 0, 8'h03, 16'h0, 2'b00);
        idle(0);
        req(0, 1, 1, 8'h05, 16'h00FF, 2'b11);
        idle(0);
        repeat (3) @(negedge clk);
        req(0, 1, 0, 8'h05, 16'h0, 2'b00);
        req(0, 0, 1, 8'h07, 16'h1111, 2'b11);
        idle(0);
        req(0, 1, 0, 8'h07, 16'h0, 2'b00);
        req(0, 0, 1, 8'h07, 16'h2222, 2'b11);
        req(0, 1, 0, 8'h07, 16'h0, 2'b00);
        req(0, 1, 0, 8'h03, 16'h0, 2'b00);
        req(0, 1, 0, 8'h10, 16'h0, 2'b00);
        idle(0);
        drain(50);

        // Variable: prefill, 20 back-to-back reads, read+write
        for (int i = 0; i < 20; i++) req(1, 0, 1, 8'(i), 16'(i), 2'b11);
        idle(1);
        base = v_rets;
        for (int i = 0; i < 20; i++) req(1, 1, 0, 8'(i), 16'h0, 2'b00);
        idle(1);
        drain(1000);
        check("var_pulse_count", v_rets - base, 20);
        req(1, 1, 1, 8'h05, 16'h00FF, 2'b11);
        idle(1);
        repeat (10) @(negedge clk);
        req(1, 1, 0, 8'h05, 16'h0, 2'b00);
        idle(1);
        drain(200);

        reset_mid();
        for (int i = 0; i < 4; i++) req(1, 1, 0, 8'(i + 10), 16'h0, 2'b00);
        idle(1);
        drain(500);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

endmodule
